// File: rtl/nap_pkg.sv
// Shared definitions for the nap timer and the main-state controller bench.
package nap_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENTRY    = 3'd1,
        ARMED    = 3'd2,
        COUNTING = 3'd3,
        DONE     = 3'd4
    } timer_state_t;

    localparam logic [3:0] KEY_STAR  = 4'hA;
    localparam logic [3:0] KEY_SHARP = 4'hB;
    localparam logic [5:0] SEC_MAX   = 6'd59;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every CLK_HZ enabled cycles.
module tick_prescaler #(
    parameter int CLK_HZ = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == TERMINAL) ? '0 : count + 1'b1;
        end
    end

    // Disabled cycles hold the count, so a paused countdown resumes mid-second.
    assign tick = en && !clr && (count == TERMINAL);

endmodule

// File: rtl/nap_timer.sv
// Nap duration loader and mm:ss countdown responding to the main-state controller.
module nap_timer
    import nap_pkg::*;
#(
    parameter int CLK_HZ   = 1000,
    parameter int AUTO_MIN = 20,
    parameter int MAX_MIN  = 99
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       init,
    input  logic       enAutoSetting,
    input  logic       enManualSetting,
    input  logic       enSleep,
    input  logic       enCancel,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       completeSetting,
    output logic       completeSleep,
    output logic [6:0] remain_min,
    output logic [5:0] remain_sec,
    output logic [6:0] entry_min
);

    timer_state_t state;
    logic         clearAll;
    logic         secondTick;
    logic         keyIsDigit;
    logic         entryInRange;
    logic [6:0]   entryShifted;

    assign clearAll     = init | enCancel;
    assign keyIsDigit   = (key_code <= 4'd9);
    assign entryInRange = (entry_min != 7'd0) && (entry_min <= 7'(MAX_MIN));
    // Keep only the last two typed digits: drop the tens digit, shift in the new one.
    assign entryShifted = (entry_min % 7'd10) * 7'd10 + {3'b000, key_code};

    tick_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .clock(clock),
        .reset(reset),
        .clr  (clearAll || (state != COUNTING)),
        .en   ((state == COUNTING) && enSleep),
        .tick (secondTick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            completeSetting <= 1'b0;
            completeSleep   <= 1'b0;
            remain_min      <= 7'd0;
            remain_sec      <= 6'd0;
            entry_min       <= 7'd0;
        end else if (clearAll) begin
            state           <= IDLE;
            completeSetting <= 1'b0;
            completeSleep   <= 1'b0;
            remain_min      <= 7'd0;
            remain_sec      <= 6'd0;
            entry_min       <= 7'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (enAutoSetting) begin
                        state           <= ARMED;
                        remain_min      <= 7'(AUTO_MIN);
                        remain_sec      <= 6'd0;
                        completeSetting <= 1'b1;
                    end else if (enManualSetting) begin
                        state     <= ENTRY;
                        entry_min <= 7'd0;
                    end
                end
                ENTRY: begin
                    if (key_valid) begin
                        if (keyIsDigit) begin
                            entry_min <= entryShifted;
                        end else if (key_code == KEY_STAR) begin
                            entry_min <= 7'd0;
                        end else if (key_code == KEY_SHARP && entryInRange) begin
                            state           <= ARMED;
                            remain_min      <= entry_min;
                            remain_sec      <= 6'd0;
                            completeSetting <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (enSleep) begin
                        state           <= COUNTING;
                        completeSetting <= 1'b0;
                    end
                end
                COUNTING: begin
                    if (secondTick) begin
                        if (remain_sec != 6'd0) begin
                            remain_sec <= remain_sec - 6'd1;
                            if (remain_min == 7'd0 && remain_sec == 6'd1) begin
                                state         <= DONE;
                                completeSleep <= 1'b1;
                            end
                        end else if (remain_min != 7'd0) begin
                            remain_min <= remain_min - 7'd1;
                            remain_sec <= SEC_MAX;
                        end else begin
                            state         <= DONE;
                            completeSleep <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    completeSleep <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nap_timer.sv
// Self-checking bench for nap_timer: vector table, directed corner sequences, random vs model.
module tb_nap_timer;

    localparam int CLK_HZ   = 4;
    localparam int AUTO_MIN = 2;
    localparam int MAX_MIN  = 99;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       init = 1'b0, enAutoSetting = 1'b0, enManualSetting = 1'b0;
    logic       enSleep = 1'b0, enCancel = 1'b0, key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       completeSetting, completeSleep;
    logic [6:0] remain_min, entry_min;
    logic [5:0] remain_sec;
    logic [21:0] dutOut;

    always #5 clock = ~clock;

    nap_timer #(.CLK_HZ(CLK_HZ), .AUTO_MIN(AUTO_MIN), .MAX_MIN(MAX_MIN)) dut (
        .clock(clock), .reset(reset), .init(init), .enAutoSetting(enAutoSetting),
        .enManualSetting(enManualSetting), .enSleep(enSleep), .enCancel(enCancel),
        .key_valid(key_valid), .key_code(key_code), .completeSetting(completeSetting),
        .completeSleep(completeSleep), .remain_min(remain_min), .remain_sec(remain_sec),
        .entry_min(entry_min)
    );

    assign dutOut = {completeSetting, completeSleep, remain_min, remain_sec, entry_min};

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: duration held as total seconds, tick phase as a cycle count.
    localparam int M_IDLE = 0, M_ENTRY = 1, M_ARMED = 2, M_COUNT = 3, M_DONE = 4;
    int mMode, mRemSecs, mEntry, mPhase;
    bit mCs, mCsl;

    function automatic void mReset();
        mMode = M_IDLE; mRemSecs = 0; mEntry = 0; mPhase = 0; mCs = 0; mCsl = 0;
    endfunction

    function automatic void mStep();
        if (init || enCancel) begin
            mReset();
        end else if (mMode == M_IDLE) begin
            if (enAutoSetting) begin
                mMode = M_ARMED; mRemSecs = AUTO_MIN * 60; mCs = 1;
            end else if (enManualSetting) begin
                mMode = M_ENTRY; mEntry = 0;
            end
        end else if (mMode == M_ENTRY) begin
            if (key_valid) begin
                if (int'(key_code) <= 9) mEntry = (mEntry % 10) * 10 + int'(key_code);
                else if (key_code == 4'hA) mEntry = 0;
                else if (key_code == 4'hB && mEntry >= 1 && mEntry <= MAX_MIN) begin
                    mMode = M_ARMED; mRemSecs = mEntry * 60; mCs = 1;
                end
            end
        end else if (mMode == M_ARMED) begin
            if (enSleep) begin
                mMode = M_COUNT; mCs = 0; mPhase = 0;
            end
        end else if (mMode == M_COUNT) begin
            if (enSleep) begin
                mPhase++;
                if (mPhase == CLK_HZ) begin
                    mPhase = 0;
                    mRemSecs--;
                    if (mRemSecs == 0) begin
                        mMode = M_DONE; mCsl = 1;
                    end
                end
            end
        end
    endfunction

    function automatic logic [21:0] mOut();
        return {mCs, mCsl, 7'(mRemSecs / 60), 6'(mRemSecs % 60), 7'(mEntry)};
    endfunction

    function automatic logic [21:0] pack(int cs, int csl, int mn, int sc, int en);
        return {1'(cs), 1'(csl), 7'(mn), 6'(sc), 7'(en)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic clearInputs();
        init = 0; enAutoSetting = 0; enManualSetting = 0; enSleep = 0;
        enCancel = 0; key_valid = 0; key_code = 4'd0;
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
        mStep();
    endtask

    task automatic stepCheck(input string name);
        advance();
        check(name, {10'd0, dutOut}, {10'd0, mOut()});
    endtask

    task automatic pulseInit();
        clearInputs(); init = 1; stepCheck("init pulse"); init = 0;
    endtask

    typedef struct {
        logic ini, aut, man, slp, can, kv;
        logic [3:0] kc;
        logic [21:0] exp;
    } vec_t;

    function automatic vec_t V(int ini, int aut, int man, int slp, int can, int kv, int kc,
                               logic [21:0] exp);
        vec_t v;
        v.ini = 1'(ini); v.aut = 1'(aut); v.man = 1'(man); v.slp = 1'(slp);
        v.can = 1'(can); v.kv = 1'(kv); v.kc = 4'(kc); v.exp = exp;
        return v;
    endfunction

    vec_t vecs[18];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        int tOneMin, tFiftyNine;
        logic [21:0] held;

        //          ini aut man slp can kv kc   cs csl mm ss entry
        vecs[0]  = V(0, 0, 1, 0, 0, 0, 0,  pack(0, 0, 0, 0, 0));
        vecs[1]  = V(0, 0, 0, 0, 0, 1, 1,  pack(0, 0, 0, 0, 1));
        vecs[2]  = V(0, 0, 0, 0, 0, 1, 2,  pack(0, 0, 0, 0, 12));
        vecs[3]  = V(0, 0, 0, 0, 0, 1, 3,  pack(0, 0, 0, 0, 23));
        vecs[4]  = V(0, 0, 0, 0, 0, 1, 4,  pack(0, 0, 0, 0, 34));
        vecs[5]  = V(0, 0, 0, 0, 0, 1, 5,  pack(0, 0, 0, 0, 45));
        vecs[6]  = V(0, 0, 0, 0, 0, 1, 10, pack(0, 0, 0, 0, 0));
        vecs[7]  = V(0, 0, 0, 0, 0, 1, 0,  pack(0, 0, 0, 0, 0));
        vecs[8]  = V(0, 0, 0, 0, 0, 1, 0,  pack(0, 0, 0, 0, 0));
        vecs[9]  = V(0, 0, 0, 0, 0, 1, 11, pack(0, 0, 0, 0, 0));
        vecs[10] = V(0, 0, 0, 0, 0, 1, 12, pack(0, 0, 0, 0, 0));
        vecs[11] = V(0, 0, 0, 0, 0, 1, 1,  pack(0, 0, 0, 0, 1));
        vecs[12] = V(0, 0, 0, 0, 0, 1, 2,  pack(0, 0, 0, 0, 12));
        vecs[13] = V(0, 0, 0, 0, 0, 1, 11, pack(1, 0, 12, 0, 12));
        vecs[14] = V(0, 0, 0, 0, 0, 1, 9,  pack(1, 0, 12, 0, 12));
        vecs[15] = V(1, 0, 0, 0, 0, 0, 0,  pack(0, 0, 0, 0, 0));
        vecs[16] = V(0, 1, 1, 0, 0, 0, 0,  pack(1, 0, 2, 0, 0));
        vecs[17] = V(0, 0, 0, 0, 1, 0, 0,  pack(0, 0, 0, 0, 0));

        // Reset state
        clearInputs();
        mReset();
        repeat (2) @(posedge clock);
        #1;
        check("reset state", {10'd0, dutOut}, 32'd0);
        reset = 1;

        // Vector table: manual entry, star, rejected confirm, auto priority, cancel
        foreach (vecs[i]) begin
            init = vecs[i].ini; enAutoSetting = vecs[i].aut; enManualSetting = vecs[i].man;
            enSleep = vecs[i].slp; enCancel = vecs[i].can; key_valid = vecs[i].kv;
            key_code = vecs[i].kc;
            advance();
            check($sformatf("vector %0d", i), {10'd0, dutOut}, {10'd0, vecs[i].exp});
        end
        clearInputs();

        // Auto load and full countdown with expiry latency and minute wrap
        pulseInit();
        enAutoSetting = 1; stepCheck("auto load"); enAutoSetting = 0;
        check("auto load value", {10'd0, dutOut}, {10'd0, pack(1, 0, AUTO_MIN, 0, 0)});
        enSleep = 1; stepCheck("sleep accept");
        cycles = 0; tOneMin = -1; tFiftyNine = -1;
        while (!completeSleep && cycles < 1000) begin
            stepCheck("countdown");
            cycles++;
            if (remain_min == 7'd1 && remain_sec == 6'd0 && tOneMin < 0) tOneMin = cycles;
            if (remain_min == 7'd0 && remain_sec == 6'd59 && tFiftyNine < 0) tFiftyNine = cycles;
        end
        check("expiry latency", cycles, 480);
        check("minute wrap spacing", tFiftyNine - tOneMin, CLK_HZ);
        check("expired value", {10'd0, dutOut}, {10'd0, pack(0, 1, 0, 0, 0)});

        // DONE hold: enables and keys must not disturb the expired state
        held = dutOut;
        for (int i = 0; i < 20; i++) begin
            enSleep = 1'($urandom_range(0, 1)); key_valid = 1'($urandom_range(0, 1));
            key_code = 4'($urandom_range(0, 15));
            enAutoSetting = 1'($urandom_range(0, 1)); enManualSetting = 1'($urandom_range(0, 1));
            stepCheck("done hold model");
        end
        check("done hold value", {10'd0, dutOut}, {10'd0, held});
        pulseInit();
        check("init clears done", {10'd0, dutOut}, 32'd0);

        // Pause: prescaler phase must survive a 10-cycle enSleep drop
        enAutoSetting = 1; stepCheck("pause load"); enAutoSetting = 0;
        enSleep = 1; stepCheck("pause accept");
        repeat (6) stepCheck("pause pre-run");
        held = dutOut;
        enSleep = 0;
        repeat (10) stepCheck("paused");
        check("paused value frozen", {10'd0, dutOut}, {10'd0, held});
        enSleep = 1;
        cycles = 0;
        while (dutOut == held && cycles < 20) begin
            stepCheck("resume");
            cycles++;
        end
        check("resume tick phase", cycles, CLK_HZ - 2);

        // Cancel during counting with a key strobe in the same cycle
        enCancel = 1; key_valid = 1; key_code = 4'd5;
        stepCheck("cancel model");
        check("cancel clears", {10'd0, dutOut}, 32'd0);
        clearInputs();

        // Asynchronous reset in the middle of a count
        enAutoSetting = 1; stepCheck("reset-test load"); enAutoSetting = 0;
        enSleep = 1;
        repeat (9) stepCheck("reset-test count");
        #2 reset = 0;
        #1 check("async reset immediate", {10'd0, dutOut}, 32'd0);
        mReset();
        clearInputs();
        repeat (2) @(posedge clock);
        #1 reset = 1;
        stepCheck("idle after reset");
        enAutoSetting = 1; stepCheck("load after reset"); enAutoSetting = 0;
        check("load after reset value", {10'd0, dutOut}, {10'd0, pack(1, 0, AUTO_MIN, 0, 0)});
        pulseInit();

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            init = (i % 600 == 599) || ($urandom_range(0, 999) == 0);
            enCancel = ($urandom_range(0, 999) == 0);
            enAutoSetting = ($urandom_range(0, 29) == 0);
            enManualSetting = ($urandom_range(0, 19) == 0);
            enSleep = ($urandom_range(0, 3) != 0);
            key_valid = ($urandom_range(0, 2) == 0);
            key_code = 4'($urandom_range(0, 12));
            stepCheck("random");
        end
        clearInputs();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
